plab3_mem_blocking_l2_cache_ctrl: RTL and testbench

Control unit for the two-way set-associative blocking L2 cache datapath: 32 sets × 2 ways, 16-byte lines, 32-bit words. It accepts one cache request at a time and sequences the datapath through tag check, data access, dirty eviction and refill. It holds the valid, dirty and replacement state, and drives the val/rdy handshakes on the cache-request, cache-response, memory-request and memory-response ports. It sits directly beside the L2 datapath and pairs with it one-to-one.

---
 rtl/plab3_mem_blocking_l2_cache_ctrl_if.sv | 35 +++
 rtl/plab3_mem_blocking_l2_cache_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_plab3_mem_blocking_l2_cache_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/plab3_mem_blocking_l2_cache_ctrl_if.sv
// Handshake bundle between the blocking L2 cache controller and its neighbours:
// cache request/response and memory request/response val/rdy pairs.
// master: the cache controller; slave: the processor side and memory side.
interface plab3_mem_blocking_l2_cache_ctrl_if;
  logic cachereq_val;
  logic cachereq_rdy;
  logic cacheresp_val;
  logic cacheresp_rdy;
  logic memreq_val;
  logic memreq_rdy;
  logic memresp_val;
  logic memresp_rdy;

  modport master (
    input  cachereq_val,
    output cachereq_rdy,
    output cacheresp_val,
    input  cacheresp_rdy,
    output memreq_val,
    input  memreq_rdy,
    input  memresp_val,
    output memresp_rdy
  );

  modport slave (
    output cachereq_val,
    input  cachereq_rdy,
    input  cacheresp_val,
    output cacheresp_rdy,
    input  memreq_val,
    output memreq_rdy,
    output memresp_val,
    input  memresp_rdy
  );
endinterface

// File: rtl/plab3_mem_blocking_l2_cache_ctrl.sv
// Control unit for the 2-way, 32-set blocking L2 cache datapath. Sequences tag
// check, data access, dirty eviction and refill; owns valid/dirty/lru state.
// Optional feature: define PLAB3_MEM_L2_LRU_EN to pick the victim from the
// per-set lru bit when both ways are valid (otherwise way 0 is the victim).
module plab3_mem_blocking_l2_cache_ctrl #(
  parameter int unsigned p_idx_shamt = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  plab3_mem_blocking_l2_cache_ctrl_if.master     bus,
  input  logic [2:0]                             cachereq_type,
  input  logic [31:0]                            cachereq_addr,
  input  logic                                   tag_match_0,
  input  logic                                   tag_match_1,
  output logic                                   cachereq_en,
  output logic                                   memresp_en,
  output logic                                   is_refill,
  output logic                                   tag_array_0_wen,
  output logic                                   tag_array_0_ren,
  output logic                                   tag_array_1_wen,
  output logic                                   tag_array_1_ren,
  output logic                                   data_array_wen,
  output logic                                   data_array_ren,
  output logic                                   read_data_reg_en,
  output logic                                   read_tag_reg_en,
  output logic                                   way_sel,
  output logic [15:0]                            data_array_wben,
  output logic [1:0]                             read_byte_sel,
  output logic [1:0]                             amo_sel,
  output logic [2:0]                             memreq_type,
  output logic [2:0]                             cacheresp_type
);

  typedef enum logic [3:0] {
    StIdle, StTc, StInit, StRd, StWr, StAmoRd, StAmoWr,
    StEvp, StEvq, StEvw, StRfq, StRfw, StRfu, StWait
  } state_e;

  state_e            state_q;
  logic              way_q;
  logic [31:0][1:0]  valid_q;
  logic [31:0][1:0]  dirty_q;
`ifdef PLAB3_MEM_L2_LRU_EN
  logic [31:0]       lru_q;
`endif

  logic [4:0] idx;
  logic [1:0] wo;
  logic       hit0, hit1, victim, victim_dirty;
  logic       unused_addr;

  assign idx          = cachereq_addr[4+p_idx_shamt +: 5];
  assign wo           = cachereq_addr[3:2];
  assign hit0         = valid_q[idx][0] & tag_match_0;
  assign hit1         = valid_q[idx][1] & tag_match_1;
  assign unused_addr  = ^cachereq_addr;
  assign victim_dirty = valid_q[idx][victim] & dirty_q[idx][victim];

  // Victim: first invalid way, else the replacement choice.
  always_comb begin
    victim = 1'b0;
    if (valid_q[idx][0] && !valid_q[idx][1]) begin
      victim = 1'b1;
    end else if (valid_q[idx][0] && valid_q[idx][1]) begin
`ifdef PLAB3_MEM_L2_LRU_EN
      victim = lru_q[idx];
`else
      victim = 1'b0;
`endif
    end
  end

  // State, selected way and per-set valid/dirty/lru bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      way_q   <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
`ifdef PLAB3_MEM_L2_LRU_EN
      lru_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle:  if (bus.cachereq_val) state_q <= StTc;
        StTc: begin
          if (cachereq_type == 3'd2) begin
            way_q   <= victim;
            state_q <= StInit;
          end else if (hit0 || hit1) begin
            way_q <= ~hit0;
            case (cachereq_type)
              3'd1:             state_q <= StWr;
              3'd3, 3'd4, 3'd5: state_q <= StAmoRd;
              default:          state_q <= StRd;
            endcase
          end else begin
            way_q   <= victim;
            state_q <= victim_dirty ? StEvp : StRfq;
          end
        end
        StInit: begin
          valid_q[idx][way_q] <= 1'b1;
          dirty_q[idx][way_q] <= 1'b0;
          state_q             <= StWait;
        end
        StRd:    state_q <= StWait;
        StWr: begin
          dirty_q[idx][way_q] <= 1'b1;
          state_q             <= StWait;
        end
        StAmoRd: state_q <= StAmoWr;
        StAmoWr: begin
          dirty_q[idx][way_q] <= 1'b1;
          state_q             <= StWait;
        end
        StEvp:   state_q <= StEvq;
        StEvq:   if (bus.memreq_rdy) state_q <= StEvw;
        StEvw:   if (bus.memresp_val) state_q <= StRfq;
        StRfq:   if (bus.memreq_rdy) state_q <= StRfw;
        StRfw:   if (bus.memresp_val) state_q <= StRfu;
        StRfu: begin
          valid_q[idx][way_q] <= 1'b1;
          dirty_q[idx][way_q] <= 1'b0;
          state_q             <= StTc;
        end
        StWait: begin
`ifdef PLAB3_MEM_L2_LRU_EN
          lru_q[idx] <= ~way_q;
`endif
          if (bus.cacheresp_rdy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Moore decode of datapath strobes and handshake outputs from the state.
  always_comb begin
    bus.cachereq_rdy  = 1'b0;
    bus.cacheresp_val = 1'b0;
    bus.memreq_val    = 1'b0;
    bus.memresp_rdy   = 1'b0;
    cachereq_en       = 1'b0;
    memresp_en        = 1'b0;
    is_refill         = 1'b0;
    tag_array_0_wen   = 1'b0;
    tag_array_0_ren   = 1'b0;
    tag_array_1_wen   = 1'b0;
    tag_array_1_ren   = 1'b0;
    data_array_wen    = 1'b0;
    data_array_ren    = 1'b0;
    read_data_reg_en  = 1'b0;
    read_tag_reg_en   = 1'b0;
    way_sel           = way_q;
    data_array_wben   = 16'h0000;
    read_byte_sel     = 2'd0;
    amo_sel           = 2'd0;
    memreq_type       = 3'd0;
    cacheresp_type    = 3'd0;
    unique case (state_q)
      StIdle: begin
        bus.cachereq_rdy = 1'b1;
        cachereq_en      = bus.cachereq_val;
      end
      StTc: begin
        tag_array_0_ren = 1'b1;
        tag_array_1_ren = 1'b1;
      end
      StInit, StRfu: begin
        is_refill       = (state_q == StRfu);
        data_array_wen  = 1'b1;
        data_array_wben = 16'hFFFF;
        tag_array_0_wen = ~way_q;
        tag_array_1_wen = way_q;
      end
      StRd, StAmoRd: begin
        data_array_ren   = 1'b1;
        read_data_reg_en = 1'b1;
        read_byte_sel    = wo;
      end
      StWr, StAmoWr: begin
        data_array_wen  = 1'b1;
        data_array_wben = 16'h000F << {wo, 2'b00};
        if (state_q == StAmoWr) begin
          case (cachereq_type)
            3'd3:    amo_sel = 2'd1;
            3'd4:    amo_sel = 2'd2;
            3'd5:    amo_sel = 2'd3;
            default: amo_sel = 2'd0;
          endcase
        end
      end
      StEvp: begin
        data_array_ren   = 1'b1;
        read_data_reg_en = 1'b1;
        read_tag_reg_en  = 1'b1;
        tag_array_0_ren  = ~way_q;
        tag_array_1_ren  = way_q;
      end
      StEvq: begin
        bus.memreq_val = 1'b1;
        memreq_type    = 3'd1;
      end
      StRfq:   bus.memreq_val = 1'b1;
      StEvw:   bus.memresp_rdy = 1'b1;
      StRfw: begin
        bus.memresp_rdy = 1'b1;
        memresp_en      = bus.memresp_val;
      end
      StWait: begin
        bus.cacheresp_val = 1'b1;
        cacheresp_type    = cachereq_type;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_plab3_mem_blocking_l2_cache_ctrl.sv
// Self-checking bench for the blocking L2 cache controller. A small datapath
// stand-in (request register, tag arrays) closes the loop; each request is
// checked for latency, memory traffic, selected way and write strobes.
module tb_plab3_mem_blocking_l2_cache_ctrl;
`ifdef PLAB3_MEM_L2_LRU_EN
  localparam bit LruEn = 1'b1;
`else
  localparam bit LruEn = 1'b0;
`endif

  typedef struct {
    logic [2:0]  typ;
    logic [31:0] addr;
    int          lat;
    int          n_ev;
    int          n_rf;
    logic        way;
    logic [15:0] wben;
    logic [1:0]  amo;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  plab3_mem_blocking_l2_cache_ctrl_if bus ();

  logic [2:0]  req_type, type_reg;
  logic [31:0] req_addr, addr_reg;
  logic        tag_match_0, tag_match_1;
  logic        cachereq_en, memresp_en, is_refill;
  logic        tag_array_0_wen, tag_array_0_ren, tag_array_1_wen, tag_array_1_ren;
  logic        data_array_wen, data_array_ren, read_data_reg_en, read_tag_reg_en, way_sel;
  logic [15:0] data_array_wben;
  logic [1:0]  read_byte_sel, amo_sel;
  logic [2:0]  memreq_type, cacheresp_type;

  plab3_mem_blocking_l2_cache_ctrl #(.p_idx_shamt(0)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cachereq_type(type_reg), .cachereq_addr(addr_reg),
    .tag_match_0(tag_match_0), .tag_match_1(tag_match_1),
    .cachereq_en(cachereq_en), .memresp_en(memresp_en), .is_refill(is_refill),
    .tag_array_0_wen(tag_array_0_wen), .tag_array_0_ren(tag_array_0_ren),
    .tag_array_1_wen(tag_array_1_wen), .tag_array_1_ren(tag_array_1_ren),
    .data_array_wen(data_array_wen), .data_array_ren(data_array_ren),
    .read_data_reg_en(read_data_reg_en), .read_tag_reg_en(read_tag_reg_en),
    .way_sel(way_sel), .data_array_wben(data_array_wben),
    .read_byte_sel(read_byte_sel), .amo_sel(amo_sel),
    .memreq_type(memreq_type), .cacheresp_type(cacheresp_type)
  );

  // Datapath stand-in: request register and tag arrays.
  logic [22:0] tag0 [32];
  logic [22:0] tag1 [32];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg <= 32'h0;
      type_reg <= 3'd0;
    end else if (cachereq_en) begin
      addr_reg <= req_addr;
      type_reg <= req_type;
    end
  end
  always @(posedge clk) begin
    if (tag_array_0_wen) tag0[addr_reg[8:4]] <= addr_reg[31:9];
    if (tag_array_1_wen) tag1[addr_reg[8:4]] <= addr_reg[31:9];
  end
  assign tag_match_0 = (tag0[addr_reg[8:4]] == addr_reg[31:9]);
  assign tag_match_1 = (tag1[addr_reg[8:4]] == addr_reg[31:9]);

  // Traffic logs: memory requests by type, non-refill data writes.
  logic [2:0]  memq [$];
  logic [17:0] wrq  [$];
  always @(posedge clk) begin
    if (!reset && bus.memreq_val && bus.memreq_rdy) memq.push_back(memreq_type);
    if (!reset && data_array_wen && !is_refill) wrq.push_back({data_array_wben, amo_sel});
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t sb_q [$];
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_sig(input string name, input int which, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = bus.cacheresp_val;
        1:       seen = bus.memreq_val;
        default: seen = bus.memresp_rdy;
      endcase
    end
    check({name, "/seen"}, 32'(seen), 32'd1);
  endtask

  // Issue one request, then compare the response against the scoreboard.
  task automatic issue(input vec_t v, input string name);
    int ms, ws, cyc, n_ev, n_rf;
    logic [17:0] wr;
    vec_t e;
    bit done, rdy_seen;
    ms = memq.size(); ws = wrq.size(); rdy_seen = 1'b0;
    for (int i = 0; i < 50 && !rdy_seen; i++) begin
      @(negedge clk);
      rdy_seen = bus.cachereq_rdy;
    end
    check({name, "/accept"}, 32'(rdy_seen), 32'd1);
    sb_q.push_back(v);
    req_type = v.typ; req_addr = v.addr; bus.cachereq_val = 1'b1;
    @(posedge clk);
    #1 bus.cachereq_val = 1'b0;
    cyc = 1; done = 1'b0;
    @(negedge clk);
    while (!done && cyc < 200) begin
      if (bus.cacheresp_val) done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    e = sb_q.pop_front();
    check({name, "/resp"}, 32'(done), 32'd1);
    if (done) begin
      n_ev = 0; n_rf = 0;
      for (int i = ms; i < memq.size(); i++) begin
        if (memq[i] == 3'd1) n_ev++;
        else n_rf++;
      end
      wr = (wrq.size() > ws) ? wrq[wrq.size()-1] : 18'h0;
      check({name, "/latency"}, 32'(cyc), 32'(e.lat));
      check({name, "/resp_type"}, 32'(cacheresp_type), 32'(e.typ));
      check({name, "/way"}, 32'(way_sel), 32'(e.way));
      check({name, "/evictions"}, 32'(n_ev), 32'(e.n_ev));
      check({name, "/refills"}, 32'(n_rf), 32'(e.n_rf));
      if (e.n_ev > 0) check({name, "/evict_first"}, 32'(memq[ms]), 32'd1);
      check({name, "/wben"}, 32'(wr[17:2]), 32'(e.wben));
      check({name, "/amo_sel"}, 32'(wr[1:0]), 32'(e.amo));
    end
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int ms;
    // {type, addr, latency, evictions, refills, way, wben, amo_sel}
    vecs[0]  = '{3'd2, 32'h1000, 3, 0, 0, 1'b0, 16'hFFFF, 2'd0};
    vecs[1]  = '{3'd0, 32'h1000, 3, 0, 0, 1'b0, 16'h0000, 2'd0};
    vecs[2]  = '{3'd0, 32'h2004, 7, 0, 1, 1'b1, 16'h0000, 2'd0};
    vecs[3]  = '{3'd1, 32'h2004, 3, 0, 0, 1'b1, 16'h00F0, 2'd0};
    vecs[4]  = '{3'd3, 32'h1000, 4, 0, 0, 1'b0, 16'h000F, 2'd1};
    vecs[5]  = '{3'd0, 32'h3008, 10, 1, 1, LruEn, 16'h0000, 2'd0};
    vecs[6]  = '{3'd2, 32'h1010, 3, 0, 0, 1'b0, 16'hFFFF, 2'd0};
    vecs[7]  = '{3'd5, 32'h1010, 4, 0, 0, 1'b0, 16'h000F, 2'd3};
    vecs[8]  = '{3'd4, 32'h1010, 4, 0, 0, 1'b0, 16'h000F, 2'd2};
    vecs[9]  = '{3'd1, 32'h1010, 3, 0, 0, 1'b0, 16'h000F, 2'd0};
    vecs[10] = '{3'd1, 32'h101C, 3, 0, 0, 1'b0, 16'hF000, 2'd0};

    reset = 1'b1;
    bus.cachereq_val = 1'b0; bus.cacheresp_rdy = 1'b1;
    bus.memreq_rdy = 1'b1;   bus.memresp_val = 1'b1;
    req_type = 3'd0; req_addr = 32'h0;
    #3;
    check("reset/cachereq_rdy", 32'(bus.cachereq_rdy), 32'd1);
    check("reset/cacheresp_val", 32'(bus.cacheresp_val), 32'd0);
    check("reset/memreq_val", 32'(bus.memreq_val), 32'd0);
    check("reset/memresp_rdy", 32'(bus.memresp_rdy), 32'd0);
    check("reset/data_array_wen", 32'(data_array_wen), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) issue(vecs[i], $sformatf("vec%0d", i));

    // Response stall: held valid, no second request accepted.
    bus.cacheresp_rdy = 1'b0;
    @(negedge clk);
    req_type = 3'd0; req_addr = 32'h1010; bus.cachereq_val = 1'b1;
    @(posedge clk);
    wait_sig("resp_stall", 0, seen);
    for (int i = 0; i < 5; i++) begin
      check("resp_stall/cacheresp_val", 32'(bus.cacheresp_val), 32'd1);
      check("resp_stall/cachereq_rdy", 32'(bus.cachereq_rdy), 32'd0);
      check("resp_stall/cachereq_en", 32'(cachereq_en), 32'd0);
      @(negedge clk);
    end
    bus.cachereq_val = 1'b0; bus.cacheresp_rdy = 1'b1;
    @(negedge clk);
    check("resp_stall/idle_after", 32'(bus.cachereq_rdy), 32'd1);

    // Memory request stall on a clean miss to an empty set.
    bus.memreq_rdy = 1'b0;
    ms = memq.size();
    req_type = 3'd0; req_addr = 32'h5020; bus.cachereq_val = 1'b1;
    @(posedge clk);
    #1 bus.cachereq_val = 1'b0;
    wait_sig("memreq_stall", 1, seen);
    for (int i = 0; i < 5; i++) begin
      check("memreq_stall/memreq_val", 32'(bus.memreq_val), 32'd1);
      check("memreq_stall/memreq_type", 32'(memreq_type), 32'd0);
      @(negedge clk);
    end
    bus.memreq_rdy = 1'b1;
    wait_sig("memreq_stall_resp", 0, seen);
    check("memreq_stall/one_request", 32'(memq.size() - ms), 32'd1);
    @(posedge clk);

    // Asynchronous reset while waiting for refill data.
    bus.memresp_val = 1'b0;
    @(negedge clk);
    req_type = 3'd0; req_addr = 32'h6040; bus.cachereq_val = 1'b1;
    @(posedge clk);
    #1 bus.cachereq_val = 1'b0;
    wait_sig("rfw_reset", 2, seen);
    #2 reset = 1'b1;
    #1;
    check("rfw_reset/memresp_rdy", 32'(bus.memresp_rdy), 32'd0);
    check("rfw_reset/memreq_val", 32'(bus.memreq_val), 32'd0);
    check("rfw_reset/cachereq_rdy", 32'(bus.cachereq_rdy), 32'd1);
    @(negedge clk);
    reset = 1'b0; bus.memresp_val = 1'b1;
    issue('{3'd0, 32'h6040, 7, 0, 1, 1'b0, 16'h0000, 2'd0}, "after_reset_6040");
    issue('{3'd0, 32'h1010, 7, 0, 1, 1'b0, 16'h0000, 2'd0}, "after_reset_1010");

    // Replacement: touch A, B, A in set 8, then miss on C.
    issue('{3'd2, 32'h1080, 3, 0, 0, 1'b0, 16'hFFFF, 2'd0}, "repl_init_a");
    issue('{3'd2, 32'h2080, 3, 0, 0, 1'b1, 16'hFFFF, 2'd0}, "repl_init_b");
    issue('{3'd0, 32'h1080, 3, 0, 0, 1'b0, 16'h0000, 2'd0}, "repl_read_a");
    issue('{3'd0, 32'h3080, 7, 0, 1, LruEn, 16'h0000, 2'd0}, "repl_miss_c");
    issue('{3'd0, 32'h1080, LruEn ? 3 : 7, 0, LruEn ? 0 : 1, 1'b0, 16'h0000, 2'd0},
          "repl_reread_a");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
